// File: rtl/system_top_if.sv
// system_top_if: control, memory and observation signals of the Mini SRC datapath.
// master drives micro-step controls; slave is the datapath itself.
interface system_top_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
);
   logic [DATA_WIDTH-1:0] inport_data;
   logic                  inport_data_ready;
   logic [DATA_WIDTH-1:0] outport_data;
   logic                  outport_in;
   logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, Rout, BAout;
   logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Rin;
   logic [4:0]            opcode;
   logic                  IncPC;
   logic                  Gra, Grb, Grc;
   logic                  con_ff_bit;
   logic                  Mem_Read, Mem_Write, Mem_enable512x32;
   logic [DATA_WIDTH-1:0] Mem_to_datapath;
   logic [DATA_WIDTH-1:0] Mem_data_to_chip;
   logic [DATA_WIDTH-1:0] MAR_address;
   logic [DATA_WIDTH-1:0] register [8];
   logic [DATA_WIDTH-1:0] registerMDR, BusMuxOut, registerPC, registerHI, registerLO, registerIR;
   logic                  mem_overide;
   logic [ADDR_WIDTH-1:0] overide_address;
   logic [DATA_WIDTH-1:0] overide_data_in;

   modport master (
      output inport_data, inport_data_ready, outport_in,
      output HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, Rout, BAout,
      output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Rin,
      output opcode, IncPC, Gra, Grb, Grc,
      output Mem_Read, Mem_Write, Mem_enable512x32,
      output mem_overide, overide_address, overide_data_in,
      input  outport_data, con_ff_bit, Mem_to_datapath, Mem_data_to_chip, MAR_address,
      input  register, registerMDR, BusMuxOut, registerPC, registerHI, registerLO, registerIR
   );

   modport slave (
      input  inport_data, inport_data_ready, outport_in,
      input  HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, Rout, BAout,
      input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Rin,
      input  opcode, IncPC, Gra, Grb, Grc,
      input  Mem_Read, Mem_Write, Mem_enable512x32,
      input  mem_overide, overide_address, overide_data_in,
      output outport_data, con_ff_bit, Mem_to_datapath, Mem_data_to_chip, MAR_address,
      output register, registerMDR, BusMuxOut, registerPC, registerHI, registerLO, registerIR
   );
endinterface

// File: rtl/system_top.sv
// system_top: Mini SRC datapath with register file, ALU, bus mux, I/O ports and 512x32 memory.
module system_top #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
) (
   input logic         Clock,
   input logic         clear,
   system_top_if.slave sys
);
   localparam int W = DATA_WIDTH;
   logic [W-1:0] r [16];
   logic [W-1:0] mem [2**ADDR_WIDTH];
   logic [W-1:0] pc, ir, mar, mdr, y, hi, lo, inport, outport;
   logic [2*W-1:0] z, alu, res;
   logic signed [2*W-1:0] prod;
   logic signed [W-1:0] quo, rem;
   logic con, cond_ok;
   logic [3:0] sel;
   logic [4:0] sh;
   logic [W-1:0] bus, c_sext, rsel, mem_rd;
   logic [ADDR_WIDTH-1:0] maddr;

   assign sel    = sys.Gra ? ir[26:23] : sys.Grb ? ir[22:19] : sys.Grc ? ir[18:15] : 4'd0;
   assign rsel   = (sys.BAout && !sys.Rout && sel == 4'd0) ? '0 : r[sel];
   assign c_sext = {{(W-19){ir[18]}}, ir[18:0]};
   assign bus    = sys.PCout      ? pc :
                   sys.MDRout     ? mdr :
                   sys.Zhi_out    ? z[2*W-1:W] :
                   sys.Zlo_out    ? z[W-1:0] :
                   sys.HIout      ? hi :
                   sys.LOout      ? lo :
                   sys.Inport_out ? inport :
                   sys.Cout       ? c_sext :
                   (sys.Rout || sys.BAout) ? rsel : '0;

   assign maddr  = mar[ADDR_WIDTH-1:0];
   assign mem_rd = (sys.Mem_Read && sys.Mem_enable512x32) ? mem[maddr] : '0;

   assign cond_ok = ir[20:19] == 2'b00 ? bus == '0 :
                    ir[20:19] == 2'b01 ? bus != '0 :
                    ir[20:19] == 2'b10 ? !bus[W-1] : bus[W-1];

   assign sh   = bus[4:0];
   assign prod = $signed({{W{y[W-1]}}, y}) * $signed({{W{bus[W-1]}}, bus});

   always_comb begin
      quo = '0;
      rem = '0;
      if (bus != '0) begin
         quo = $signed(y) / $signed(bus);
         rem = $signed(y) % $signed(bus);
      end
   end

   always_comb begin
      res = {{W{1'b0}}, bus};
      case (sys.opcode)
         5'b00011: res = {{W{1'b0}}, y + bus};
         5'b00100: res = {{W{1'b0}}, y - bus};
         5'b00101: res = {{W{1'b0}}, y & bus};
         5'b00110: res = {{W{1'b0}}, y | bus};
         5'b00111: res = {{W{1'b0}}, (y >> sh) | (y << (W - sh))};
         5'b01000: res = {{W{1'b0}}, (y << sh) | (y >> (W - sh))};
         5'b01001: res = {{W{1'b0}}, y >> sh};
         5'b01010: res = {{W{1'b0}}, $signed(y) >>> sh};
         5'b01011: res = {{W{1'b0}}, y << sh};
         5'b01111: res = {rem, quo};
         5'b10000: res = prod;
         5'b10001: res = {{W{1'b0}}, -bus};
         5'b10010: res = {{W{1'b0}}, ~bus};
         default:  res = {{W{1'b0}}, bus};
      endcase
   end

   assign alu = sys.IncPC ? {{W{1'b0}}, bus + 1'b1} : res;

   always_ff @(posedge Clock) begin
      if (clear) begin
         for (int i = 0; i < 16; i++) r[i] <= '0;
         pc      <= '0;
         ir      <= '0;
         mar     <= '0;
         mdr     <= '0;
         y       <= '0;
         z       <= '0;
         hi      <= '0;
         lo      <= '0;
         inport  <= '0;
         outport <= '0;
         con     <= 1'b0;
      end else begin
         if (sys.Rin) r[sel] <= bus;
         if (sys.PCin) pc <= bus;
         if (sys.IRin) ir <= bus;
         if (sys.MARin) mar <= bus;
         if (sys.MDRin) mdr <= sys.Mem_Read ? mem_rd : bus;
         if (sys.Yin) y <= bus;
         if (sys.Zin) z <= alu;
         if (sys.HIin) hi <= bus;
         if (sys.LOin) lo <= bus;
         if (sys.inport_data_ready) inport <= sys.inport_data;
         if (sys.outport_in) outport <= bus;
         if (sys.Gra && (sys.Rout || sys.BAout)) con <= cond_ok;
      end
   end

   // Memory survives clear; the direct-load path must work while the core is held in reset.
   always_ff @(posedge Clock) begin
      if (sys.mem_overide) mem[sys.overide_address] <= sys.overide_data_in;
      else if (sys.Mem_Write && sys.Mem_enable512x32) mem[maddr] <= mdr;
   end

   assign sys.outport_data     = outport;
   assign sys.con_ff_bit       = con;
   assign sys.Mem_to_datapath  = mem_rd;
   assign sys.Mem_data_to_chip = mdr;
   assign sys.MAR_address      = mar;
   assign sys.registerMDR      = mdr;
   assign sys.BusMuxOut        = bus;
   assign sys.registerPC       = pc;
   assign sys.registerHI       = hi;
   assign sys.registerLO       = lo;
   assign sys.registerIR       = ir;
   for (genvar i = 0; i < 8; i++) begin : g_obs
      assign sys.register[i] = r[i];
   end
endmodule

// File: tb/tb_system_top.sv
// tb_system_top: vector table, hand-written micro-step sequences and a randomized ALU
// check against an arithmetic reference model.
module tb_system_top;
   logic Clock = 1'b0;
   logic clear = 1'b1;
   int total = 0;
   int bad = 0;

   system_top_if sys ();
   system_top dut (.Clock(Clock), .clear(clear), .sys(sys));

   always #5 Clock = ~Clock;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] z;
   } vec_t;

   typedef struct {
      logic [1:0]  c;
      logic [31:0] v;
      logic        exp;
   } con_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic idle();
      sys.inport_data_ready = 0; sys.outport_in = 0;
      sys.HIout = 0; sys.LOout = 0; sys.Zhi_out = 0; sys.Zlo_out = 0; sys.PCout = 0;
      sys.MDRout = 0; sys.Inport_out = 0; sys.Cout = 0; sys.Rout = 0; sys.BAout = 0;
      sys.MARin = 0; sys.Zin = 0; sys.PCin = 0; sys.MDRin = 0; sys.IRin = 0;
      sys.Yin = 0; sys.HIin = 0; sys.LOin = 0; sys.Rin = 0;
      sys.opcode = 0; sys.IncPC = 0; sys.Gra = 0; sys.Grb = 0; sys.Grc = 0;
      sys.Mem_Read = 0; sys.Mem_Write = 0; sys.Mem_enable512x32 = 0;
      sys.mem_overide = 0; sys.overide_address = 0; sys.overide_data_in = 0;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
      idle();
   endtask

   // Loads the inport, then leaves Inport_out asserted for the caller's destination.
   task automatic put(input logic [31:0] v);
      sys.inport_data = v;
      sys.inport_data_ready = 1;
      tick();
      sys.Inport_out = 1;
   endtask

   task automatic poke(input logic [8:0] a, input logic [31:0] d);
      sys.mem_overide = 1; sys.overide_address = a; sys.overide_data_in = d;
      tick();
   endtask

   task automatic zout(output logic [63:0] z);
      sys.Zhi_out = 1; sys.HIin = 1; tick();
      sys.Zlo_out = 1; sys.LOin = 1; tick();
      z = {sys.registerHI, sys.registerLO};
   endtask

   task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] z);
      put(a); sys.Yin = 1; tick();
      put(b); sys.opcode = op; sys.Zin = 1; tick();
      zout(z);
   endtask

   task automatic fetch();
      sys.PCout = 1; sys.IncPC = 1; sys.MARin = 1; sys.Zin = 1; tick();
      sys.Zlo_out = 1; sys.PCin = 1; sys.MDRin = 1; sys.Mem_Read = 1; sys.Mem_enable512x32 = 1; tick();
      sys.MDRout = 1; sys.IRin = 1; tick();
   endtask

   function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int s = int'(b[4:0]);
      logic [31:0] t = a;
      longint p;
      int q, rm;
      case (op)
         5'd3:  return {32'h0, a + b};
         5'd4:  return {32'h0, a - b};
         5'd5:  return {32'h0, a & b};
         5'd6:  return {32'h0, a | b};
         5'd7:  begin repeat (s) t = {t[0], t[31:1]}; return {32'h0, t}; end
         5'd8:  begin repeat (s) t = {t[30:0], t[31]}; return {32'h0, t}; end
         5'd9:  return {32'h0, a >> s};
         5'd10: begin t = $signed(a) >>> s; return {32'h0, t}; end
         5'd11: return {32'h0, a << s};
         5'd15: begin
            if (b == 0) return 64'h0;
            q = int'(a) / int'(b);
            rm = int'(a) % int'(b);
            return {rm, q};
         end
         5'd16: begin p = longint'(int'(a)) * longint'(int'(b)); return p; end
         5'd17: return {32'h0, 32'h0 - b};
         5'd18: return {32'h0, ~b};
         default: return {32'h0, b};
      endcase
   endfunction

   initial begin
      vec_t tbl[$];
      con_t ct[$];
      logic [63:0] z;
      logic [4:0] ops[16] = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                              5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd31};

      idle();
      clear = 1;
      tick();
      clear = 0;
      #1;
      check("rst_pc", sys.registerPC, 0);
      check("rst_ir", sys.registerIR, 0);
      check("rst_mdr", sys.registerMDR, 0);
      check("rst_mar", sys.MAR_address, 0);
      check("rst_hi", sys.registerHI, 0);
      check("rst_lo", sys.registerLO, 0);
      check("rst_out", sys.outport_data, 0);
      check("rst_bus", sys.BusMuxOut, 0);
      check("rst_con", sys.con_ff_bit, 0);
      check("rst_memrd", sys.Mem_to_datapath, 0);
      for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), sys.register[i], 0);

      // mfhi: fetch from PC=0 and move HI into Ra=6
      poke(9'd0, 32'hC3000000);
      put(32'h1234); sys.HIin = 1; tick();
      fetch();
      sys.Gra = 1; sys.HIout = 1; sys.Rin = 1; tick();
      check("mfhi_pc", sys.registerPC, 1);
      check("mfhi_ir", sys.registerIR, 32'hC3000000);
      check("mfhi_r6", sys.register[6], 32'h1234);

      // mflo: fetch from PC=1 and move LO into Ra=7
      poke(9'd1, 32'hC3800000);
      put(32'h55); sys.LOin = 1; tick();
      fetch();
      sys.Gra = 1; sys.LOout = 1; sys.Rin = 1; tick();
      check("mflo_r7", sys.register[7], 32'h55);
      check("mflo_pc", sys.registerPC, 2);

      // IncPC overrides the opcode
      put(32'd41); sys.IncPC = 1; sys.opcode = 5'd16; sys.Zin = 1; tick();
      zout(z);
      check("incpc", z, 64'd42);

      tbl.push_back('{5'd16, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB});
      tbl.push_back('{5'd15, 32'd20, 32'd6, {32'd2, 32'd3}});
      tbl.push_back('{5'd15, 32'd20, 32'd0, 64'h0});
      tbl.push_back('{5'd15, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD});
      tbl.push_back('{5'd3, 32'd1, 32'd2, 64'd3});
      tbl.push_back('{5'd4, 32'd5, 32'd7, 64'h00000000_FFFFFFFE});
      tbl.push_back('{5'd5, 32'hF0F0, 32'hFF00, 64'hF000});
      tbl.push_back('{5'd6, 32'hF0F0, 32'h0F0F, 64'hFFFF});
      tbl.push_back('{5'd7, 32'd1, 32'd1, 64'h80000000});
      tbl.push_back('{5'd8, 32'h80000000, 32'd1, 64'd1});
      tbl.push_back('{5'd9, 32'h80000000, 32'd4, 64'h08000000});
      tbl.push_back('{5'd10, 32'h80000000, 32'd4, 64'hF8000000});
      tbl.push_back('{5'd11, 32'd1, 32'd31, 64'h80000000});
      tbl.push_back('{5'd17, 32'd0, 32'd1, 64'hFFFFFFFF});
      tbl.push_back('{5'd18, 32'd0, 32'd0, 64'hFFFFFFFF});
      tbl.push_back('{5'd0, 32'd9, 32'h1234, 64'h1234});
      foreach (tbl[i]) begin
         run_alu(tbl[i].op, tbl[i].a, tbl[i].b, z);
         check($sformatf("vec%0d_op%0d", i, tbl[i].op), z, tbl[i].z);
      end

      for (int i = 0; i < 40; i++) begin
         logic [4:0] op = ops[$urandom_range(0, 15)];
         logic [31:0] a = $urandom;
         logic [31:0] b = $urandom;
         if (i % 4 == 0) b = $urandom_range(0, 40);
         if (op == 5'd15 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 1;
         run_alu(op, a, b, z);
         check($sformatf("rnd%0d_op%0d", i, op), z, model(op, a, b));
      end

      // Memory write/read at MAR=500
      put(32'd500); sys.MARin = 1; tick();
      put(32'h14); sys.MDRin = 1; tick();
      check("mem_chip", sys.Mem_data_to_chip, 32'h14);
      sys.Mem_Write = 1; sys.Mem_enable512x32 = 1; tick();
      put(32'h0); sys.MDRin = 1; tick();
      sys.Mem_Read = 1; sys.Mem_enable512x32 = 1; sys.MDRin = 1;
      #1;
      check("mem_rd500", sys.Mem_to_datapath, 32'h14);
      tick();
      check("mem_mdr500", sys.registerMDR, 32'h14);

      // MAR=512 wraps to word 0
      put(32'd512); sys.MARin = 1; tick();
      check("mar512", sys.MAR_address, 32'd512);
      put(32'hABCD); sys.MDRin = 1; tick();
      sys.Mem_Write = 1; sys.Mem_enable512x32 = 1; tick();
      put(32'd0); sys.MARin = 1; tick();
      sys.Mem_Read = 1; sys.Mem_enable512x32 = 1; sys.MDRin = 1;
      #1;
      check("mem_wrap", sys.Mem_to_datapath, 32'hABCD);
      tick();
      check("mem_wrap_mdr", sys.registerMDR, 32'hABCD);

      // CON flip-flop over all four conditions; last entry leaves CON at 0
      ct.push_back('{2'b00, 32'd0, 1'b1});
      ct.push_back('{2'b00, 32'd5, 1'b0});
      ct.push_back('{2'b01, 32'd5, 1'b1});
      ct.push_back('{2'b01, 32'd0, 1'b0});
      ct.push_back('{2'b11, 32'h80000000, 1'b1});
      ct.push_back('{2'b10, 32'd3, 1'b1});
      ct.push_back('{2'b10, 32'h80000000, 1'b0});
      foreach (ct[i]) begin
         put((32'd2 << 23) | (32'(ct[i].c) << 19)); sys.IRin = 1; tick();
         put(ct[i].v); sys.Gra = 1; sys.Rin = 1; tick();
         sys.Gra = 1; sys.Rout = 1;
         #1;
         check($sformatf("con%0d_bus", i), sys.BusMuxOut, ct[i].v);
         tick();
         check($sformatf("con%0d", i), sys.con_ff_bit, ct[i].exp);
      end

      // BAout reads R0 as zero while Rout sees the stored value
      put(32'h0); sys.IRin = 1; tick();
      put(32'd7); sys.Gra = 1; sys.Rin = 1; tick();
      check("r0_load", sys.register[0], 7);
      sys.Gra = 1; sys.Rout = 1;
      #1;
      check("r0_rout", sys.BusMuxOut, 7);
      sys.Rout = 0; sys.BAout = 1;
      #1;
      check("r0_baout", sys.BusMuxOut, 0);
      tick();
      check("con_baout", sys.con_ff_bit, 1);

      put(32'hCAFE); sys.outport_in = 1; tick();
      check("outport", sys.outport_data, 32'hCAFE);

      // Bus priority: PC beats inport
      put(32'h99); sys.PCout = 1;
      #1;
      check("bus_prio", sys.BusMuxOut, sys.registerPC);
      sys.PCout = 0; sys.PCin = 1;
      tick();
      check("pc_load", sys.registerPC, 32'h99);

      // clear beats load enables; direct memory load still lands during clear
      put(32'h77); sys.PCin = 1; sys.HIin = 1;
      sys.mem_overide = 1; sys.overide_address = 9'd3; sys.overide_data_in = 32'h777;
      clear = 1;
      tick();
      clear = 0;
      check("clr_pc", sys.registerPC, 0);
      check("clr_hi", sys.registerHI, 0);
      check("clr_out", sys.outport_data, 0);
      check("clr_con", sys.con_ff_bit, 0);
      check("clr_r0", sys.register[0], 0);
      put(32'd3); sys.MARin = 1; tick();
      sys.Mem_Read = 1; sys.Mem_enable512x32 = 1;
      #1;
      check("clr_memload", sys.Mem_to_datapath, 32'h777);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/system_top.md
# system_top

Top-level datapath-plus-memory block of the ELEC 374 Mini SRC processor. It holds the register file, the special registers (PC, IR, MAR, MDR, Y, Z, HI, LO), the ALU, the internal bus multiplexer, the I/O ports and a 512×32 word memory. Every control signal is an input, so a testbench or control unit drives the block one micro-step per clock. Key internal registers are exposed for observation.

## Interface
- DATA_WIDTH, default 32: bus and register width.
- ADDR_WIDTH, default 9: memory address width (512 words).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  synchronous, active-high reset.
- inport_data  in  32  external input-port data.
- inport_data_ready  in  1  loads inport register from inport_data.
- outport_data  out  32  output-port register.
- outport_in  in  1  loads outport from BusMuxOut.
- HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, Rout, BAout  in  1 each  bus-source selects.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Rin  in  1 each  register load enables.
- opcode  in  5  ALU operation.
- IncPC  in  1  forces ALU result to BusMuxOut+1.
- Gra, Grb, Grc  in  1 each  select register field Ra/Rb/Rc of IR.
- con_ff_bit  out  1  CON flip-flop.
- Mem_Read, Mem_Write, Mem_enable512x32  in  1 each  memory controls.
- Mem_to_datapath  out  32  memory read data.
- Mem_data_to_chip  out  32  memory write data; equals MDR.
- MAR_address  out  32  MAR contents.
- register  out  8×32 unpacked array  R0–R7.
- registerMDR, BusMuxOut, registerPC, registerHI, registerLO, registerIR  out  32 each  observation taps.
- mem_overide  in  1  direct memory load.
- overide_address  in  9  direct-load address.
- overide_data_in  in  32  direct-load data.

## Operation
- IR fields:
  - opcode IR[31:27]
  - Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]
  - C = IR[18:0] sign-extended
  - branch condition IR[20:19]
- Register select: Gra picks Ra, else Grb picks Rb, else Grc picks Rc (this priority order).
  - Rin writes the selected register of 16×32 from the bus.
  - Rout drives the selected register onto the bus.
  - BAout drives it too, except R0 reads as 0.
- Bus source priority: PCout > MDRout > Zhi_out > Zlo_out > HIout > LOout > Inport_out > Cout > Rout/BAout.
  - With no source asserted, the bus is 0.
- ALU inputs: A = Y, B = bus. Result is 64-bit; Zin latches it into Z.
- ALU operations by opcode (non-multiply results zero-extend into Zhi):
  - 00011 add, 00100 sub, 00101 and, 00110 or
  - 00111 ror, 01000 rol, 01001 shr, 01010 shra, 01011 shl (shift amount B[4:0], shifts apply A by B)
  - 01111 div, signed: Zlo = quotient, Zhi = remainder. Divide by 0 gives Z = 0.
  - 10000 mul, signed 64-bit product.
  - 10001 neg B, 10010 not B.
  - All other codes pass B through.
- IncPC overrides opcode: Z = {32'b0, bus+1}.
- MDR input: Mem_to_datapath when Mem_Read, else bus.
- Memory read:
  - Combinational: Mem_to_datapath = mem[MAR[8:0]] when Mem_Read & Mem_enable512x32, else 0.
- Memory write and direct load:
  - Write: rising edge with Mem_Write & Mem_enable512x32 stores mem[MAR[8:0]] ← MDR.
  - mem_overide: rising edge stores mem[overide_address] ← overide_data_in. It has priority over a normal write and is honored even during clear.
- CON FF:
  - Loads on any edge where Gra & (Rout|BAout) are both asserted.
  - Condition on bus value per IR[20:19]: 00 → =0, 01 → ≠0, 10 → ≥0 (MSB 0), 11 → <0.
- Inport register loads on inport_data_ready; Inport_out drives it onto the bus.

## Timing
- clear high at an edge zeroes: R0–R15, PC, IR, MAR, MDR, Y, Z, HI, LO, inport, outport, CON.
  - Memory is not cleared.
  - clear beats all load enables in the same cycle.
- Every load enable captures BusMuxOut, or the ALU result for Z, at the rising edge where it is high.
  - Latency is 1 cycle. Combinational outputs settle within the cycle.
- A register that is both bus source and destination in one cycle captures the old value; this is legal.
- Fetch sequence:
  - T0: PCout, IncPC, MARin, Zin
  - T1: Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32 (MDR captures mem[MAR] at the same edge)
  - T2: MDRout, IRin
- MAR wraps modulo 512 via its [8:0] field; upper MAR bits are ignored.

## Test plan
- Reset: pulse clear for 1 cycle → every observation output 0 and con_ff_bit 0.
- mfhi:
  - Setup: override mem[0] = 0xC3000000. Load HI = 0x1234 via inport, then Inport_out+HIin.
  - Stimulus: run fetch T0–T2, then T3 Gra+HIout+Rin.
  - Required: PC = 1, IR = 0xC3000000, R6 = 0x1234.
- mflo:
  - Setup: mem[1] = 0xC3800000, LO = 0x55.
  - Stimulus: fetch from PC = 1, then T3 Gra+LOout+Rin.
  - Required: R7 = 0x55, PC = 2.
- mul: Y = 0xFFFFFFFD, bus 7, opcode 10000, Zin → Zhi = 0xFFFFFFFF, Zlo = 0xFFFFFFEB.
- div: Y = 20, bus 6, opcode 01111 → Zlo = 3, Zhi = 2. Divide by 0 → Z = 0.
- Memory:
  - MAR = 500, MDR = 0x14, Mem_Write+enable → then MDRin+Mem_Read gives MDR = 0x14.
  - MAR = 512 accesses address 0.
